// File: rtl/tomasulo_dispatch_rename_unit_pkg.sv
// Shared types and constants for the dispatch/rename slice: tag sizing,
// target-unit encoding, register-status entries and operand resolution.
package tomasulo_pkg;

  localparam int unsigned TAG_W    = 6;
  localparam int unsigned NUM_TAGS = 64;  // must equal 2**TAG_W

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   count_t;

  localparam count_t COUNT_FULL = count_t'(NUM_TAGS);

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_AGU = 2'd1,
    UNIT_MUL = 2'd2,
    UNIT_DIV = 2'd3
  } unit_e;

  typedef struct packed {
    logic pending;
    tag_t tag;
  } rst_entry_t;

  typedef struct packed {
    logic [31:0] data;
    tag_t        tag;
    logic        valid;
  } operand_t;

  // Resolve one source: x0, ready register, same-cycle CDB bypass, or pending tag.
  function automatic operand_t read_operand(input logic [4:0]  rs,
                                            input logic [31:0] rf_data,
                                            input rst_entry_t  ent,
                                            input logic        cdb_valid,
                                            input tag_t        cdb_tag,
                                            input logic [31:0] cdb_data);
    operand_t o;
    o.data  = '0;
    o.tag   = '0;
    o.valid = 1'b1;
    if (rs == '0) begin
      o.data = '0;
    end else if (!ent.pending) begin
      o.data = rf_data;
    end else if (cdb_valid && (cdb_tag == ent.tag)) begin
      o.data = cdb_data;
    end else begin
      o.valid = 1'b0;
      o.tag   = ent.tag;
    end
    return o;
  endfunction

endpackage

// File: rtl/tomasulo_dispatch_rename_unit_if.sv
// Dispatch-side bus: instruction handshake, CDB snoop, queue write bus and back pressure.
interface tomasulo_dispatch_rename_unit_if;
  import tomasulo_pkg::*;

  logic        iq_valid;
  logic        iq_ready;
  unit_e       iq_unit;
  logic [4:0]  iq_rs1;
  logic [4:0]  iq_rs2;
  logic [4:0]  iq_rd;
  logic        iq_rs2_used;
  logic        iq_rd_used;
  logic        iq_use_imm;
  logic [31:0] iq_imm;
  logic [2:0]  iq_funct3;
  logic [2:0]  iq_alu_ext;
  logic        iq_agu_ls;

  logic        cdb_valid;
  tag_t        cdb_tag;
  logic [31:0] cdb_data;

  logic [31:0] queue_op1_data;
  tag_t        queue_op1_tag;
  logic        queue_op1_data_valid;
  logic [31:0] queue_op2_data;
  tag_t        queue_op2_tag;
  logic        queue_op2_data_valid;
  tag_t        queue_rd_tag;
  logic        queue_rd_tag_valid;
  logic [2:0]  queue_funct3;
  logic [2:0]  queue_alu_ext;
  logic        queue_agu_ls;
  logic [31:0] queue_agu_imm;
  logic        queue_alu_en;
  logic        queue_agu_en;
  logic        queue_mul_en;
  logic        queue_div_en;
  logic        queue_alu_full;
  logic        queue_agu_full;
  logic        queue_mul_full;
  logic        queue_div_full;

  count_t      free_tag_count;

  modport master (
    output iq_valid, iq_unit, iq_rs1, iq_rs2, iq_rd, iq_rs2_used, iq_rd_used,
           iq_use_imm, iq_imm, iq_funct3, iq_alu_ext, iq_agu_ls,
           cdb_valid, cdb_tag, cdb_data,
           queue_alu_full, queue_agu_full, queue_mul_full, queue_div_full,
    input  iq_ready,
           queue_op1_data, queue_op1_tag, queue_op1_data_valid,
           queue_op2_data, queue_op2_tag, queue_op2_data_valid,
           queue_rd_tag, queue_rd_tag_valid, queue_funct3, queue_alu_ext,
           queue_agu_ls, queue_agu_imm,
           queue_alu_en, queue_agu_en, queue_mul_en, queue_div_en,
           free_tag_count
  );

  modport slave (
    input  iq_valid, iq_unit, iq_rs1, iq_rs2, iq_rd, iq_rs2_used, iq_rd_used,
           iq_use_imm, iq_imm, iq_funct3, iq_alu_ext, iq_agu_ls,
           cdb_valid, cdb_tag, cdb_data,
           queue_alu_full, queue_agu_full, queue_mul_full, queue_div_full,
    output iq_ready,
           queue_op1_data, queue_op1_tag, queue_op1_data_valid,
           queue_op2_data, queue_op2_tag, queue_op2_data_valid,
           queue_rd_tag, queue_rd_tag_valid, queue_funct3, queue_alu_ext,
           queue_agu_ls, queue_agu_imm,
           queue_alu_en, queue_agu_en, queue_mul_en, queue_div_en,
           free_tag_count
  );

endinterface

// File: rtl/tomasulo_dispatch_rename_unit_tag_fifo.sv
// Free-tag pool: circular buffer preloaded with 0..NUM_TAGS-1 on reset.
// The head is the next tag to allocate; freed tags are appended at the tail.
module tomasulo_tag_fifo
  import tomasulo_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_pop,
  input  logic   i_push,
  input  tag_t   i_push_tag,
  output tag_t   o_head,
  output count_t o_count
);

  tag_t   r_mem [NUM_TAGS];
  tag_t   r_head_ptr;
  tag_t   r_tail_ptr;
  count_t r_count;

  // Pointers are TAG_W bits wide, so wrapping mod NUM_TAGS is the natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        r_mem[i] <= i[TAG_W-1:0];
      end
      r_head_ptr <= '0;
      r_tail_ptr <= '0;
      r_count    <= COUNT_FULL;
    end else begin
      if (i_push) begin
        r_mem[r_tail_ptr] <= i_push_tag;
        r_tail_ptr        <= r_tail_ptr + tag_t'(1);
      end
      if (i_pop) begin
        r_head_ptr <= r_head_ptr + tag_t'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + count_t'(1);
        2'b01:   r_count <= r_count - count_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_head_ptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && (r_count == COUNT_FULL)));

endmodule

// File: rtl/tomasulo_dispatch_rename_unit.sv
// In-order dispatch/rename stage: reads RF and register status, allocates a
// destination tag, drives the reservation-queue bus and snoops the CDB.
module tomasulo_dispatch_rename_unit
  import tomasulo_pkg::*;
(
  input logic clk,
  input logic rst,
  tomasulo_dispatch_rename_unit_if.slave bus
);

  logic [31:0] r_rf  [32];
  rst_entry_t  r_rst [32];

  logic     w_need_tag;
  logic     w_unit_full;
  logic     w_ready;
  logic     w_dispatch;
  logic     w_pop;
  tag_t     w_head;
  count_t   w_count;
  operand_t w_op1;
  operand_t w_op2;

  tomasulo_tag_fifo u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_pop      (w_pop),
    .i_push     (bus.cdb_valid),
    .i_push_tag (bus.cdb_tag),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  // Handshake: head-of-line blocking on the target queue and tag availability.
  always_comb begin
    w_need_tag = bus.iq_rd_used && (bus.iq_rd != '0);
    case (bus.iq_unit)
      UNIT_ALU: w_unit_full = bus.queue_alu_full;
      UNIT_AGU: w_unit_full = bus.queue_agu_full;
      UNIT_MUL: w_unit_full = bus.queue_mul_full;
      default:  w_unit_full = bus.queue_div_full;
    endcase
    w_ready    = !rst && !w_unit_full && (!w_need_tag || (w_count != '0));
    w_dispatch = bus.iq_valid && w_ready;
    w_pop      = w_dispatch && w_need_tag;
  end

  // Operand selection from pre-edge RF/RST state, with CDB bypass and immediate override.
  always_comb begin
    w_op1 = read_operand(bus.iq_rs1, r_rf[bus.iq_rs1], r_rst[bus.iq_rs1],
                         bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    w_op2.data  = '0;
    w_op2.tag   = '0;
    w_op2.valid = 1'b1;
    if ((bus.iq_unit == UNIT_ALU) && bus.iq_use_imm) begin
      w_op2.data = bus.iq_imm;
    end else if (bus.iq_rs2_used) begin
      w_op2 = read_operand(bus.iq_rs2, r_rf[bus.iq_rs2], r_rst[bus.iq_rs2],
                           bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
  end

  assign bus.iq_ready             = w_ready;
  assign bus.queue_op1_data       = w_op1.data;
  assign bus.queue_op1_tag        = w_op1.tag;
  assign bus.queue_op1_data_valid = w_op1.valid;
  assign bus.queue_op2_data       = w_op2.data;
  assign bus.queue_op2_tag        = w_op2.tag;
  assign bus.queue_op2_data_valid = w_op2.valid;
  assign bus.queue_rd_tag         = w_head;
  assign bus.queue_rd_tag_valid   = w_need_tag;
  assign bus.queue_funct3         = bus.iq_funct3;
  assign bus.queue_alu_ext        = bus.iq_alu_ext;
  assign bus.queue_agu_ls         = bus.iq_agu_ls;
  assign bus.queue_agu_imm        = bus.iq_imm;
  assign bus.queue_alu_en         = w_dispatch && (bus.iq_unit == UNIT_ALU);
  assign bus.queue_agu_en         = w_dispatch && (bus.iq_unit == UNIT_AGU);
  assign bus.queue_mul_en         = w_dispatch && (bus.iq_unit == UNIT_MUL);
  assign bus.queue_div_en         = w_dispatch && (bus.iq_unit == UNIT_DIV);
  assign bus.free_tag_count       = w_count;

  // CDB writeback and rename; the rename is written last so it overrides a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 32; r++) begin
        r_rf[r]  <= '0;
        r_rst[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (bus.cdb_valid && r_rst[r].pending && (r_rst[r].tag == bus.cdb_tag)) begin
          r_rf[r]          <= bus.cdb_data;
          r_rst[r].pending <= 1'b0;
        end
      end
      if (w_pop) begin
        r_rst[bus.iq_rd].pending <= 1'b1;
        r_rst[bus.iq_rd].tag     <= w_head;
      end
    end
  end

endmodule

// File: tb/tb_tomasulo_dispatch_rename_unit.sv
// Directed bench for the dispatch/rename unit: reset, renaming, CDB bypass,
// stale tags, tag exhaustion, back pressure and mid-stream reset.
module tb_tomasulo_dispatch_rename_unit;
  import tomasulo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  tomasulo_dispatch_rename_unit_if bus ();

  tomasulo_dispatch_rename_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iq_valid = 1'b0;  bus.iq_unit = UNIT_ALU;
    bus.iq_rs1 = '0;      bus.iq_rs2 = '0;        bus.iq_rd = '0;
    bus.iq_rs2_used = 1'b0; bus.iq_rd_used = 1'b0; bus.iq_use_imm = 1'b0;
    bus.iq_imm = '0;      bus.iq_funct3 = '0;     bus.iq_alu_ext = '0;
    bus.iq_agu_ls = 1'b0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0;       bus.cdb_data = '0;
    bus.queue_alu_full = 1'b0; bus.queue_agu_full = 1'b0;
    bus.queue_mul_full = 1'b0; bus.queue_div_full = 1'b0;
  endtask

  task automatic set_instr(input logic valid, input unit_e unit,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic rs2_used, input logic rd_used, input logic use_imm,
                           input logic [31:0] imm);
    bus.iq_valid = valid;       bus.iq_unit = unit;
    bus.iq_rs1 = rs1;           bus.iq_rs2 = rs2;       bus.iq_rd = rd;
    bus.iq_rs2_used = rs2_used; bus.iq_rd_used = rd_used;
    bus.iq_use_imm = use_imm;   bus.iq_imm = imm;
  endtask

  task automatic set_cdb(input logic v, input tag_t tag, input logic [31:0] data);
    bus.cdb_valid = v; bus.cdb_tag = tag; bus.cdb_data = data;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    set_instr(1'b1, UNIT_ALU, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b1, 32'd5);
    #2;
    n_tests++; if (bus.iq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b expected 0", bus.iq_ready); end
    n_tests++; if (bus.queue_alu_en !== 1'b0) begin n_fail++; $display("FAIL reset_alu_en: got %0b expected 0", bus.queue_alu_en); end
    n_tests++; if (bus.free_tag_count !== 7'd64) begin n_fail++; $display("FAIL reset_count: got %0d expected 64", bus.free_tag_count); end
    tick();
    n_tests++; if (bus.queue_alu_en !== 1'b0) begin n_fail++; $display("FAIL reset_hold_en: got %0b expected 0", bus.queue_alu_en); end
    bus.iq_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_tests++; if (bus.free_tag_count !== 7'd64) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 64", bus.free_tag_count); end
    tick();
  endtask

  task automatic test_alu_imm();
    set_instr(1'b1, UNIT_ALU, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b1, 32'd5);
    bus.iq_funct3 = 3'b101; bus.iq_alu_ext = 3'b010;
    #1;
    n_tests++; if (bus.queue_alu_en !== 1'b1) begin n_fail++; $display("FAIL imm_alu_en: got %0b expected 1", bus.queue_alu_en); end
    n_tests++; if ({bus.queue_agu_en, bus.queue_mul_en, bus.queue_div_en} !== 3'b000) begin n_fail++; $display("FAIL imm_other_en: got %03b expected 000", {bus.queue_agu_en, bus.queue_mul_en, bus.queue_div_en}); end
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_data} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL imm_op1: got v%0b %0h expected v1 0", bus.queue_op1_data_valid, bus.queue_op1_data); end
    n_tests++; if ({bus.queue_op2_data_valid, bus.queue_op2_data} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL imm_op2: got v%0b %0h expected v1 5", bus.queue_op2_data_valid, bus.queue_op2_data); end
    n_tests++; if ({bus.queue_rd_tag_valid, bus.queue_rd_tag} !== {1'b1, 6'd0}) begin n_fail++; $display("FAIL imm_rd_tag: got v%0b %0d expected v1 0", bus.queue_rd_tag_valid, bus.queue_rd_tag); end
    n_tests++; if ({bus.queue_funct3, bus.queue_alu_ext} !== 6'b101_010) begin n_fail++; $display("FAIL imm_fwd: got %06b expected 101010", {bus.queue_funct3, bus.queue_alu_ext}); end
    tick();
    idle();
    #1;
    n_tests++; if (bus.free_tag_count !== 7'd63) begin n_fail++; $display("FAIL imm_count: got %0d expected 63", bus.free_tag_count); end
  endtask

  task automatic test_pending_read();
    set_instr(1'b1, UNIT_ALU, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    #1;
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_tag} !== {1'b0, 6'd0}) begin n_fail++; $display("FAIL pend_op1: got v%0b t%0d expected v0 t0", bus.queue_op1_data_valid, bus.queue_op1_tag); end
    tick();
    bus.iq_valid = 1'b0;
    set_cdb(1'b1, 6'd0, 32'h1234);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    #1;
    n_tests++; if (bus.free_tag_count !== 7'd64) begin n_fail++; $display("FAIL pend_count: got %0d expected 64", bus.free_tag_count); end
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_data} !== {1'b1, 32'h1234}) begin n_fail++; $display("FAIL pend_wb: got v%0b %0h expected v1 1234", bus.queue_op1_data_valid, bus.queue_op1_data); end
    idle();
  endtask

  task automatic test_cdb_bypass();
    // Free list head is now tag 1: x3->1, x4->2, x5->3.
    for (int r = 3; r <= 5; r++) begin
      set_instr(1'b1, UNIT_ALU, 5'd0, 5'd0, 5'(r), 1'b0, 1'b1, 1'b1, 32'd0);
      #1;
      n_tests++; if (bus.queue_rd_tag !== 6'(r - 2)) begin n_fail++; $display("FAIL byp_alloc_x%0d: got %0d expected %0d", r, bus.queue_rd_tag, r - 2); end
      tick();
    end
    set_instr(1'b1, UNIT_MUL, 5'd5, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 32'd0);
    set_cdb(1'b1, 6'd3, 32'hCAFE);
    #1;
    n_tests++; if ({bus.queue_mul_en, bus.queue_alu_en} !== 2'b10) begin n_fail++; $display("FAIL byp_en: got mul%0b alu%0b expected mul1 alu0", bus.queue_mul_en, bus.queue_alu_en); end
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_data} !== {1'b1, 32'hCAFE}) begin n_fail++; $display("FAIL byp_op1: got v%0b %0h expected v1 cafe", bus.queue_op1_data_valid, bus.queue_op1_data); end
    n_tests++; if ({bus.queue_op2_data_valid, bus.queue_op2_tag} !== {1'b0, 6'd2}) begin n_fail++; $display("FAIL byp_op2: got v%0b t%0d expected v0 t2", bus.queue_op2_data_valid, bus.queue_op2_tag); end
    n_tests++; if (bus.queue_rd_tag !== 6'd4) begin n_fail++; $display("FAIL byp_rd_tag: got %0d expected 4", bus.queue_rd_tag); end
    tick();
    idle();
    #1;
    n_tests++; if (bus.free_tag_count !== 7'd61) begin n_fail++; $display("FAIL byp_count: got %0d expected 61", bus.free_tag_count); end
    bus.iq_rs1 = 5'd5;
    #1;
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_data} !== {1'b1, 32'hCAFE}) begin n_fail++; $display("FAIL byp_x5: got v%0b %0h expected v1 cafe", bus.queue_op1_data_valid, bus.queue_op1_data); end
    bus.iq_rs1 = 5'd6;
    #1;
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_tag} !== {1'b0, 6'd4}) begin n_fail++; $display("FAIL byp_x6: got v%0b t%0d expected v0 t4", bus.queue_op1_data_valid, bus.queue_op1_tag); end
    idle();
  endtask

  task automatic test_two_writes();
    for (int k = 0; k < 2; k++) begin
      set_instr(1'b1, UNIT_ALU, 5'd0, 5'd0, 5'd2, 1'b0, 1'b1, 1'b1, 32'd0);
      #1;
      n_tests++; if (bus.queue_rd_tag !== 6'(5 + k)) begin n_fail++; $display("FAIL ww_alloc%0d: got %0d expected %0d", k, bus.queue_rd_tag, 5 + k); end
      tick();
    end
    idle();
    set_cdb(1'b1, 6'd5, 32'hAAAA);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    bus.iq_rs1 = 5'd2;
    #1;
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_tag} !== {1'b0, 6'd6}) begin n_fail++; $display("FAIL ww_stale: got v%0b t%0d expected v0 t6", bus.queue_op1_data_valid, bus.queue_op1_tag); end
    n_tests++; if (bus.free_tag_count !== 7'd60) begin n_fail++; $display("FAIL ww_count1: got %0d expected 60", bus.free_tag_count); end
    set_cdb(1'b1, 6'd6, 32'hBBBB);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    #1;
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_data} !== {1'b1, 32'hBBBB}) begin n_fail++; $display("FAIL ww_final: got v%0b %0h expected v1 bbbb", bus.queue_op1_data_valid, bus.queue_op1_data); end
    n_tests++; if (bus.free_tag_count !== 7'd61) begin n_fail++; $display("FAIL ww_count2: got %0d expected 61", bus.free_tag_count); end
    idle();
  endtask

  task automatic test_rename_wins();
    set_instr(1'b1, UNIT_ALU, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 32'd0);
    tick();
    set_cdb(1'b1, 6'd7, 32'h7777);
    #1;
    n_tests++; if (bus.queue_rd_tag !== 6'd8) begin n_fail++; $display("FAIL rw_rd_tag: got %0d expected 8", bus.queue_rd_tag); end
    tick();
    idle();
    bus.iq_rs1 = 5'd7;
    #1;
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_tag} !== {1'b0, 6'd8}) begin n_fail++; $display("FAIL rw_pending: got v%0b t%0d expected v0 t8", bus.queue_op1_data_valid, bus.queue_op1_tag); end
    n_tests++; if (bus.free_tag_count !== 7'd60) begin n_fail++; $display("FAIL rw_count: got %0d expected 60", bus.free_tag_count); end
    set_cdb(1'b1, 6'd8, 32'h8888);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    #1;
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_data} !== {1'b1, 32'h8888}) begin n_fail++; $display("FAIL rw_final: got v%0b %0h expected v1 8888", bus.queue_op1_data_valid, bus.queue_op1_data); end
    idle();
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      set_instr(1'b1, UNIT_ALU, 5'd0, 5'd0, 5'((i % 31) + 1), 1'b0, 1'b1, 1'b1, 32'd0);
      #1;
      n_tests++; if (bus.queue_rd_tag !== 6'(i)) begin n_fail++; $display("FAIL ex_alloc%0d: got %0d expected %0d", i, bus.queue_rd_tag, i); end
      tick();
    end
    set_instr(1'b1, UNIT_ALU, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b1, 32'd0);
    #1;
    n_tests++; if ({bus.iq_ready, bus.queue_alu_en} !== 2'b00) begin n_fail++; $display("FAIL ex_blocked: got rdy%0b en%0b expected rdy0 en0", bus.iq_ready, bus.queue_alu_en); end
    n_tests++; if (bus.free_tag_count !== 7'd0) begin n_fail++; $display("FAIL ex_count0: got %0d expected 0", bus.free_tag_count); end
    set_instr(1'b1, UNIT_AGU, 5'd1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 32'h10);
    bus.iq_agu_ls = 1'b1;
    #1;
    n_tests++; if ({bus.iq_ready, bus.queue_agu_en, bus.queue_rd_tag_valid} !== 3'b110) begin n_fail++; $display("FAIL ex_store: got rdy%0b en%0b rdv%0b expected 1 1 0", bus.iq_ready, bus.queue_agu_en, bus.queue_rd_tag_valid); end
    n_tests++; if ({bus.queue_agu_ls, bus.queue_agu_imm} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL ex_store_imm: got ls%0b %0h expected ls1 10", bus.queue_agu_ls, bus.queue_agu_imm); end
    n_tests++; if ({bus.queue_op2_data_valid, bus.queue_op2_tag} !== {1'b0, 6'd39}) begin n_fail++; $display("FAIL ex_store_op2: got v%0b t%0d expected v0 t39", bus.queue_op2_data_valid, bus.queue_op2_tag); end
    tick();
    idle();
    set_cdb(1'b1, 6'd7, 32'hDEAD);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    bus.iq_rs1 = 5'd8;
    #1;
    n_tests++; if (bus.free_tag_count !== 7'd1) begin n_fail++; $display("FAIL ex_count1: got %0d expected 1", bus.free_tag_count); end
    n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_tag} !== {1'b0, 6'd38}) begin n_fail++; $display("FAIL ex_stale_x8: got v%0b t%0d expected v0 t38", bus.queue_op1_data_valid, bus.queue_op1_tag); end
    set_instr(1'b1, UNIT_ALU, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b1, 32'd0);
    #1;
    n_tests++; if ({bus.queue_alu_en, bus.queue_rd_tag_valid, bus.queue_rd_tag} !== {2'b11, 6'd7}) begin n_fail++; $display("FAIL ex_realloc: got en%0b v%0b t%0d expected en1 v1 t7", bus.queue_alu_en, bus.queue_rd_tag_valid, bus.queue_rd_tag); end
    tick();
    idle();
    #1;
    n_tests++; if (bus.free_tag_count !== 7'd0) begin n_fail++; $display("FAIL ex_count_end: got %0d expected 0", bus.free_tag_count); end
  endtask

  task automatic test_back_pressure();
    idle();
    bus.queue_mul_full = 1'b1;
    set_instr(1'b1, UNIT_MUL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    #1;
    n_tests++; if ({bus.iq_ready, bus.queue_mul_en} !== 2'b00) begin n_fail++; $display("FAIL bp_full: got rdy%0b en%0b expected 0 0", bus.iq_ready, bus.queue_mul_en); end
    tick();
    n_tests++; if (bus.queue_mul_en !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got %0b expected 0", bus.queue_mul_en); end
    bus.queue_mul_full = 1'b0;
    #1;
    n_tests++; if ({bus.iq_ready, bus.queue_mul_en} !== 2'b11) begin n_fail++; $display("FAIL bp_release: got rdy%0b en%0b expected 1 1", bus.iq_ready, bus.queue_mul_en); end
    bus.iq_unit = UNIT_DIV;
    #1;
    n_tests++; if ({bus.queue_div_en, bus.queue_mul_en} !== 2'b10) begin n_fail++; $display("FAIL bp_div: got div%0b mul%0b expected 1 0", bus.queue_div_en, bus.queue_mul_en); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if ({bus.iq_ready, bus.free_tag_count} !== {1'b0, 7'd64}) begin n_fail++; $display("FAIL mid_rst: got rdy%0b cnt%0d expected rdy0 cnt64", bus.iq_ready, bus.free_tag_count); end
    tick();
    rst = 1'b0;
    tick();
    for (int r = 1; r < 32; r++) begin
      bus.iq_rs1 = 5'(r);
      #1;
      n_tests++; if ({bus.queue_op1_data_valid, bus.queue_op1_data} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL mid_x%0d: got v%0b %0h expected v1 0", r, bus.queue_op1_data_valid, bus.queue_op1_data); end
    end
    set_instr(1'b1, UNIT_ALU, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 32'd0);
    #1;
    n_tests++; if ({bus.queue_rd_tag, bus.free_tag_count} !== {6'd0, 7'd64}) begin n_fail++; $display("FAIL mid_head: got t%0d cnt%0d expected t0 cnt64", bus.queue_rd_tag, bus.free_tag_count); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_imm();
    test_pending_read();
    test_cdb_bypass();
    test_two_writes();
    test_rename_wins();
    test_exhaust();
    test_back_pressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
